// File: rtl/bcd_display_driver.sv
// 12-bit binary to 4-digit BCD converter (double-dabble) with a multiplexed 7-segment scan.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (units never blanked).
module bcd_display_driver #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [11:0] capture;
  logic [15:0] scratch;
  logic [15:0] adj;

  logic [15:0] presc;
  logic [1:0]  idx;
  logic [3:0]  nib;
  logic        blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < 4; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      capture <= '0;
      scratch <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            capture <= value;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, capture} <= {adj[14:0], capture, 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd11)
            state <= DONE;
        end
        DONE: begin
          bcd   <= scratch;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    nib   = bcd[3:0];
    blank = 1'b0;
    case (idx)
      2'd0: nib = bcd[3:0];
      2'd1: nib = bcd[7:4];
      2'd2: nib = bcd[11:8];
      2'd3: nib = bcd[15:12];
      default: nib = bcd[3:0];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (idx)
      2'd1:    blank = (bcd[15:4] == 12'h000);
      2'd2:    blank = (bcd[15:8] == 8'h00);
      2'd3:    blank = (bcd[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`endif
  end

  // Scan runs freely; an/seg are registered together from the current index and bcd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      an    <= 4'b1110;
      seg   <= 7'b1000000;
    end else begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + 16'd1;
      end
      an  <= ~(4'b0001 << idx);
      seg <= blank ? 7'b1111111 : seg7(nib);
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed self-checking bench for bcd_display_driver (SCAN_DIV=4); honours LEADING_ZERO_BLANK_EN.
module tb_bcd_display_driver;

  logic        clk;
  logic        rst_n;
  logic [11:0] value;
  logic        load;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks;
  int errors;

  bcd_display_driver #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .load  (load),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .seg   (seg),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] value;
    logic [15:0] expect_bcd;
  } vec_t;

  vec_t       vecs [7];
  logic [6:0] seg_tab [10];
  logic [3:0] an_tab [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reset, load v on the first edge after release, then check latency and the scan pattern.
  task automatic scan_run(input logic [11:0] v, input logic [15:0] exp_bcd, input logic blank_lz);
    logic [3:0] d;
    int unsigned ix;
    logic [6:0] es;
    tick();
    rst_n = 1'b0;
    #2;
    value = v;
    load  = 1'b1;
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 1) load = 1'b0;
      if (k == 13) check("scan_pre_done", {31'd0, done}, 32'd0);
      if (k == 14) begin
        check("first_load_done", {31'd0, done}, 32'd1);
        check("first_load_bcd", {16'd0, bcd}, {16'd0, exp_bcd});
      end
      if (k >= 15) begin
        ix = ((k - 1) / 4) % 4;
        d  = exp_bcd[ix*4 +: 4];
        es = seg_tab[d];
        if (blank_lz && ix != 0 && (exp_bcd >> (ix*4)) == 16'd0) es = 7'b1111111;
        check("scan_an", {28'd0, an}, {28'd0, an_tab[ix]});
        check("scan_seg", {25'd0, seg}, {25'd0, es});
      end
    end
  endtask

  initial begin
    int   done_cnt;
    logic busy_ok;
    logic done_low;
    logic lz;
    checks = 0;
    errors = 0;
`ifdef LEADING_ZERO_BLANK_EN
    lz = 1'b1;
`else
    lz = 1'b0;
`endif

    vecs[0] = '{12'd4095, 16'h4095};
    vecs[1] = '{12'd0,    16'h0000};
    vecs[2] = '{12'd1000, 16'h1000};
    vecs[3] = '{12'd123,  16'h0123};
    vecs[4] = '{12'd9,    16'h0009};
    vecs[5] = '{12'd59,   16'h0059};
    vecs[6] = '{12'd2048, 16'h2048};
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    rst_n = 1'b0;
    value = '0;
    load  = 1'b0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bcd", {16'd0, bcd}, 32'd0);
    check("reset_an", {28'd0, an}, 32'b1110);
    check("reset_seg", {25'd0, seg}, 32'b1000000);
    tick();
    rst_n = 1'b1;
    tick();

    // Conversion table: busy through edges N..N+12, done+bcd after N+13, hold after.
    for (int i = 0; i < 7; i++) begin
      value = vecs[i].value;
      load  = 1'b1;
      tick();
      load  = 1'b0;
      value = 12'hABC;
      busy_ok  = 1'b1;
      done_low = 1'b1;
      for (int j = 0; j <= 12; j++) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (done !== 1'b0) done_low = 1'b0;
        if (j < 12) tick();
      end
      check("conv_busy_window", {31'd0, busy_ok}, 32'd1);
      check("conv_no_early_done", {31'd0, done_low}, 32'd1);
      tick();
      check("conv_done", {31'd0, done}, 32'd1);
      check("conv_busy_low", {31'd0, busy}, 32'd0);
      check("conv_bcd", {16'd0, bcd}, {16'd0, vecs[i].expect_bcd});
      tick();
      check("conv_done_pulse", {31'd0, done}, 32'd0);
      check("conv_bcd_hold", {16'd0, bcd}, {16'd0, vecs[i].expect_bcd});
    end

    // Busy collision: loads at N+3 and during DONE (edge N+13) are ignored.
    done_cnt = 0;
    value = 12'd123;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      value = 12'd999;
      load  = (j == 3 || j == 13);
      tick();
      load  = 1'b0;
      if (done) done_cnt++;
    end
    check("collide_done_count", done_cnt, 32'd1);
    check("collide_bcd", {16'd0, bcd}, 32'h0123);

    // Asynchronous reset mid-SHIFT aborts the conversion.
    value = 12'd4095;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_bcd", {16'd0, bcd}, 32'd0);
    check("abort_an", {28'd0, an}, 32'b1110);
    check("abort_seg", {25'd0, seg}, 32'b1000000);
    tick();
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (20) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_bcd_zero", {16'd0, bcd}, 32'd0);

    scan_run(12'd1234, 16'h1234, 1'b0);
    scan_run(12'd7, 16'h0007, lz);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_driver.md
BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, giving clock cycles per displayed digit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port value  input  12  binary count from the upstream 12-bit selector (0..4095).
REQ-005 SHALL have port load  input  1  single-cycle strobe that starts a conversion of value.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse when bcd is updated.
REQ-008 SHALL have port bcd  output  16  four packed BCD digits: [15:12] thousands down to [3:0] units.
REQ-009 SHALL have port seg  output  7  active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-010 SHALL have port an  output  4  active-low digit enables; an[0] is units and an[3] is thousands.

Function
REQ-011 Conversion FSM SHALL have states IDLE, SHIFT and DONE.
- IDLE->SHIFT on load=1.
- SHIFT->DONE after exactly 12 shift cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-012 On load in IDLE, SHALL capture value into a shift register, clear the 16-bit scratch register, and raise busy from the next cycle.
REQ-013 Each SHIFT cycle SHALL first add 3 to every scratch nibble >= 5, then shift {scratch, capture} left by one bit (double-dabble).
REQ-014 In DONE, SHALL copy scratch into bcd, assert done for exactly that cycle, and deassert busy.
REQ-015 Latency: for load sampled at edge N, done and the new bcd SHALL both be visible after edge N+13.
REQ-016 load while busy=1 (SHIFT or DONE) SHALL be ignored, with no effect on the conversion in flight.
REQ-017 bcd SHALL hold its last result between conversions; intermediate scratch values SHALL never appear on bcd, seg or an.
REQ-018 Scan prescaler SHALL count 0..SCAN_DIV-1 and wrap. On each wrap, the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-019 Scan SHALL run continuously, independent of the FSM, including during conversions.
REQ-020 an SHALL be one-hot-low for the current index: 1110, 1101, 1011, 0111 for index 0, 1, 2, 3.
REQ-021 seg SHALL be the active-low 7-segment code of the bcd nibble selected by the index. Digits 0-9 SHALL decode as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-022 A nibble value of 10-15 SHALL display blank (1111111). Such values are unreachable under normal operation.
REQ-023 seg and an SHALL be registered and SHALL change on the same edge.

Reset
REQ-024 While rst_n=0, SHALL immediately force the following, regardless of clk:
- FSM to IDLE;
- busy=0, done=0, bcd=16'h0000;
- scratch, capture, prescaler and digit index to 0;
- an=1110, seg=1000000.
REQ-025 Reset asserted mid-conversion SHALL abort it. No done pulse SHALL occur for the aborted conversion.
REQ-026 After rst_n deasserts, the first load SHALL be honoured on the first rising edge.

Configuration
REQ-027 With macro LEADING_ZERO_BLANK_EN defined, any digit whose nibble and all higher nibbles are zero SHALL show seg=1111111.
- an still cycles normally.
- The units digit is never blanked.
REQ-028 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be displayed, including leading zeros.

Verification
REQ-029 Reset: hold rst_n=0 mid-SHIFT -> busy=0, bcd=0000, an=1110, seg=1000000 asynchronously; no done pulse follows.
REQ-030 Conversion: value=4095, load at edge N -> busy=1 for edges N+1..N+12, done=1 and bcd=16'h4095 after edge N+13; repeat for value=0 -> 16'h0000 and value=1000 -> 16'h1000.
REQ-031 Busy collision: load with 123, then load with 999 three cycles later -> single done pulse, bcd=16'h0123.
REQ-032 Scan, with SCAN_DIV=4 and bcd=16'h1234 -> an steps 1110, 1101, 1011, 0111 every 4 cycles, with seg respectively 0011001, 0110000, 0100100, 1111001.
REQ-033 Blanking, with LEADING_ZERO_BLANK_EN and value=7 -> an[3..1] digits show 1111111, units shows 1111000. Without the macro, the same stimulus gives upper digits 1000000.
